// File: rtl/softreg_router.sv
// softreg_router: soft-register address router between the shell and the
// engine CSR slaves.
//   clk, rst_n      clock, synchronous active-low reset
//   host_req        shell request {valid,isWrite,addr,data}, no back-pressure
//   host_resp       one pulse per read, in request order {valid,data}
//   slv_req         one request port per slave, 1-cycle pulses
//   slv_resp        one response port per slave
//   timeout_count   saturating count of reads whose slave never answered
//   unmapped_count  saturating count of reads+writes hitting no slave
//   stray_count     saturating count of cycles with unexpected slave responses
//   overflow        sticky, a host request was dropped on a full queue

package softreg_pkg;
    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;
endpackage

module softreg_router
    import softreg_pkg::*;
#(
    parameter int unsigned NUM_SLAVES                 = 2,
    parameter int unsigned SLAVE_BASE [NUM_SLAVES]    = '{200, 0},
    parameter int unsigned SLAVE_LAST [NUM_SLAVES]    = '{255, 199},
    parameter int unsigned CMDQ_DEPTH                 = 4,
    parameter int unsigned TIMEOUT_CYCLES             = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  SoftRegReq   host_req,
    output SoftRegResp  host_resp,
    output SoftRegReq   slv_req [NUM_SLAVES],
    input  SoftRegResp  slv_resp [NUM_SLAVES],
    output logic [15:0] timeout_count,
    output logic [15:0] unmapped_count,
    output logic [15:0] stray_count,
    output logic        overflow
);

    localparam int unsigned SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned PTR_W  = $clog2(CMDQ_DEPTH);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PTR_W:0]    Q_FULL        = (PTR_W + 1)'(CMDQ_DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_LAST     = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [63:0]       DATA_UNMAPPED = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0]       DATA_TIMEOUT  = 64'hDEAD_DEAD_DEAD_DEAD;

    typedef struct packed {
        logic        is_write;
        logic [31:0] addr;
        logic [63:0] data;
    } cmd_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // Command queue
    cmd_t             q_mem [CMDQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   q_cnt;
    logic             q_empty;
    logic             q_full;
    logic             push;
    logic             pop;

    // Decode stage: the popped head sits here for one cycle while its
    // address is decoded, then it is issued or answered at the next edge.
    cmd_t             stg;
    logic             stg_valid;
    logic             stg_hit;
    logic [SEL_W-1:0] stg_sel;

    state_t            state;
    logic [SEL_W-1:0]  cur_sel;
    logic [WCNT_W-1:0] wait_cnt;

    logic        resp_hit;
    logic [63:0] resp_data;
    logic        stray;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    assign q_empty = (q_cnt == '0);
    assign q_full  = (q_cnt == Q_FULL);

    // A mapped read in the decode stage will move the FSM to WAIT at the next
    // edge, so nothing behind it may be popped until that read completes.
    assign pop  = (state == ST_IDLE) && !q_empty && !(stg_valid && !stg.is_write && stg_hit);
    assign push = host_req.valid && (!q_full || pop);

    // Lowest-index matching slave wins.
    always_comb begin
        stg_hit = 1'b0;
        stg_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!stg_hit && stg.addr >= SLAVE_BASE[i] && stg.addr <= SLAVE_LAST[i]) begin
                stg_hit = 1'b1;
                stg_sel = SEL_W'(i);
            end
        end
    end

    // Only the slave we are waiting on may answer; anything else is stray.
    always_comb begin
        resp_hit  = 1'b0;
        resp_data = '0;
        stray     = 1'b0;
        for (int unsigned j = 0; j < NUM_SLAVES; j++) begin
            if (slv_resp[j].valid) begin
                if (state == ST_WAIT && cur_sel == SEL_W'(j)) begin
                    resp_hit  = 1'b1;
                    resp_data = slv_resp[j].data;
                end else begin
                    stray = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            host_resp      <= '0;
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                slv_req[i] <= '0;
            end
            timeout_count  <= '0;
            unmapped_count <= '0;
            stray_count    <= '0;
            overflow       <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            q_cnt          <= '0;
            stg            <= '0;
            stg_valid      <= 1'b0;
            state          <= ST_IDLE;
            cur_sel        <= '0;
            wait_cnt       <= '0;
        end else begin
            host_resp <= '0;
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                slv_req[i] <= '0;
            end

            if (push) begin
                q_mem[wr_ptr] <= '{is_write: host_req.isWrite, addr: host_req.addr, data: host_req.data};
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                stg    <= q_mem[rd_ptr];
            end
            q_cnt     <= q_cnt + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
            stg_valid <= pop;

            if (host_req.valid && !push) begin
                overflow <= 1'b1;
            end

            if (stray) begin
                stray_count <= sat_inc(stray_count);
            end

            case (state)
                ST_IDLE: begin
                    if (stg_valid) begin
                        if (stg_hit) begin
                            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                                if (stg_sel == SEL_W'(i)) begin
                                    slv_req[i] <= '{valid: 1'b1, isWrite: stg.is_write,
                                                    addr: stg.addr, data: stg.data};
                                end
                            end
                            if (!stg.is_write) begin
                                state    <= ST_WAIT;
                                cur_sel  <= stg_sel;
                                wait_cnt <= '0;
                            end
                        end else begin
                            unmapped_count <= sat_inc(unmapped_count);
                            if (!stg.is_write) begin
                                host_resp <= '{valid: 1'b1, data: DATA_UNMAPPED};
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    // A response in the final wait cycle still wins over the timeout.
                    if (resp_hit) begin
                        host_resp <= '{valid: 1'b1, data: resp_data};
                        state     <= ST_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        host_resp     <= '{valid: 1'b1, data: DATA_TIMEOUT};
                        timeout_count <= sat_inc(timeout_count);
                        state         <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_softreg_router.sv
`timescale 1ns/1ps
module tb_softreg_router;
    import softreg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    SoftRegReq   host_req;
    SoftRegResp  host_resp;
    SoftRegReq   slv_req [2];
    SoftRegResp  slv_resp [2];
    logic [15:0] timeout_count;
    logic [15:0] unmapped_count;
    logic [15:0] stray_count;
    logic        overflow;

    always #5 clk = ~clk;

    softreg_router #(
        .NUM_SLAVES(2),
        .CMDQ_DEPTH(4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .host_req(host_req),
        .host_resp(host_resp),
        .slv_req(slv_req),
        .slv_resp(slv_resp),
        .timeout_count(timeout_count),
        .unmapped_count(unmapped_count),
        .stray_count(stray_count),
        .overflow(overflow)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    logic [63:0] slv_tag [2];
    bit          slv_silent [2];
    int unsigned inj_cyc [2];

    typedef struct {
        int unsigned slv;
        logic        wr;
        logic [31:0] addr;
        logic [63:0] data;
        int unsigned due;
    } req_exp_t;

    typedef struct {
        logic [63:0] data;
        int unsigned due;
    } rsp_exp_t;

    req_exp_t exp_slv [$];
    rsp_exp_t exp_rsp [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_req(input int unsigned slv, input logic wr, input logic [31:0] addr,
                           input logic [63:0] data, input int unsigned due);
        req_exp_t e;
        e.slv = slv; e.wr = wr; e.addr = addr; e.data = data; e.due = due;
        exp_slv.push_back(e);
    endtask

    task automatic add_rsp(input logic [63:0] data, input int unsigned due);
        rsp_exp_t e;
        e.data = data; e.due = due;
        exp_rsp.push_back(e);
    endtask

    // Called at a negedge; the request is sampled at the next posedge.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [63:0] data);
        host_req = '{valid: 1'b1, isWrite: wr, addr: addr, data: data};
        @(negedge clk);
        host_req = '0;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while ((exp_rsp.size() != 0 || exp_slv.size() != 0) && i < 400) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_drain"}, 128'(exp_rsp.size() + exp_slv.size()), 128'(0));
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_host_resp"}, 128'(host_resp), 128'(0));
        check({tag, "_slv_req0"}, 128'(slv_req[0]), 128'(0));
        check({tag, "_slv_req1"}, 128'(slv_req[1]), 128'(0));
        check({tag, "_timeout_cnt"}, 128'(timeout_count), 128'(0));
        check({tag, "_unmapped_cnt"}, 128'(unmapped_count), 128'(0));
        check({tag, "_stray_cnt"}, 128'(stray_count), 128'(0));
        check({tag, "_overflow"}, 128'(overflow), 128'(0));
    endtask

    // Slave model: registered 1-cycle read response, data = tag + addr.
    initial begin
        logic        pend_v [2];
        logic [63:0] pend_d [2];
        for (int s = 0; s < 2; s++) begin
            slv_resp[s] = '0;
            pend_v[s]   = 1'b0;
            pend_d[s]   = '0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int s = 0; s < 2; s++) begin
                if (inj_cyc[s] == cyc) begin
                    slv_resp[s] = '{valid: 1'b1, data: slv_tag[s]};
                end else begin
                    slv_resp[s] = '{valid: pend_v[s], data: pend_v[s] ? pend_d[s] : 64'd0};
                end
                pend_v[s] = slv_req[s].valid && !slv_req[s].isWrite && !slv_silent[s];
                pend_d[s] = slv_tag[s] + 64'(slv_req[s].addr);
            end
        end
    end

    // Output monitor / scoreboard consumer.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                for (int s = 0; s < 2; s++) begin
                    if (slv_req[s].valid) begin
                        if (exp_slv.size() == 0) begin
                            check("slvreq_unexp", 128'(slv_req[s].valid), 128'(0));
                        end else begin
                            req_exp_t e;
                            e = exp_slv.pop_front();
                            check("slvreq_port", 128'(s), 128'(e.slv));
                            check("slvreq_wr", 128'(slv_req[s].isWrite), 128'(e.wr));
                            check("slvreq_addr", 128'(slv_req[s].addr), 128'(e.addr));
                            check("slvreq_data", 128'(slv_req[s].data), 128'(e.data));
                            if (e.due != 0) check("slvreq_cycle", 128'(cyc), 128'(e.due));
                        end
                    end else begin
                        check("slvreq_idle", 128'(slv_req[s]), 128'(0));
                    end
                end
                if (host_resp.valid) begin
                    if (exp_rsp.size() == 0) begin
                        check("resp_unexp", 128'(host_resp.valid), 128'(0));
                    end else begin
                        rsp_exp_t e;
                        e = exp_rsp.pop_front();
                        check("resp_data", 128'(host_resp.data), 128'(e.data));
                        if (e.due != 0) check("resp_cycle", 128'(cyc), 128'(e.due));
                    end
                end else begin
                    check("resp_idle", 128'(host_resp.data), 128'(0));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t;
        rst_n         = 1'b0;
        host_req      = '0;
        slv_tag[0]    = 64'h1234 - 64'd221;
        slv_tag[1]    = 64'h1_0000_0000;
        slv_silent[0] = 1'b0;
        slv_silent[1] = 1'b0;
        inj_cyc[0]    = 32'hFFFF_FFFF;
        inj_cyc[1]    = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Mapped read with a 1-cycle slave.
        t = cyc + 1;
        add_req(0, 1'b0, 221, 64'd0, t + 2);
        add_rsp(64'h1234, t + 4);
        send(1'b0, 221, 64'd0);
        drain("rd221");

        // Write to slave1 then read slave0 back to back.
        t = cyc + 1;
        add_req(1, 1'b1, 10, 64'h55, t + 2);
        add_req(0, 1'b0, 205, 64'd0, t + 3);
        add_rsp(slv_tag[0] + 64'd205, t + 5);
        send(1'b1, 10, 64'h55);
        send(1'b0, 205, 64'd0);
        drain("wr_rd");

        // Unmapped accesses and range boundaries.
        t = cyc + 1;
        add_rsp(64'hFFFF_FFFF_FFFF_FFFF, t + 2);
        add_rsp(64'hFFFF_FFFF_FFFF_FFFF, t + 4);
        add_req(1, 1'b0, 199, 64'd0, t + 5);
        add_rsp(slv_tag[1] + 64'd199, t + 7);
        add_req(0, 1'b0, 255, 64'd0, t + 9);
        add_rsp(slv_tag[0] + 64'd255, t + 11);
        send(1'b0, 300, 64'd0);
        send(1'b1, 400, 64'h77);
        send(1'b0, 256, 64'd0);
        send(1'b0, 199, 64'd0);
        send(1'b0, 255, 64'd0);
        drain("unmapped");
        check("unmapped_cnt", 128'(unmapped_count), 128'(3));

        // Timeout, then a late response counted as stray.
        slv_silent[0] = 1'b1;
        t = cyc + 1;
        add_req(0, 1'b0, 222, 64'd0, t + 2);
        add_rsp(64'hDEAD_DEAD_DEAD_DEAD, t + 66);
        send(1'b0, 222, 64'd0);
        drain("timeout");
        check("timeout_cnt", 128'(timeout_count), 128'(1));
        check("stray_before", 128'(stray_count), 128'(0));
        inj_cyc[0] = cyc + 1;
        repeat (3) @(negedge clk);
        check("stray_late", 128'(stray_count), 128'(1));

        // Queue overflow: six reads, slave0 silent for the first.
        t = cyc + 1;
        add_req(0, 1'b0, 200, 64'd0, t + 2);
        add_rsp(64'hDEAD_DEAD_DEAD_DEAD, t + 66);
        for (int i = 1; i <= 4; i++) begin
            add_req(0, 1'b0, 32'(200 + i), 64'd0, 0);
            add_rsp(slv_tag[0] + 64'(200 + i), 0);
        end
        add_req(0, 1'b0, 206, 64'd0, 0);
        add_rsp(slv_tag[0] + 64'd206, 0);
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 32'(200 + i), 64'd0);
            if (i == 4) check("ovf_not_yet", 128'(overflow), 128'(0));
        end
        check("ovf_set", 128'(overflow), 128'(1));
        slv_silent[0] = 1'b0;
        // Queue still full here; the push lands on the same edge as a pop.
        while (cyc < t + 66) @(negedge clk);
        send(1'b0, 206, 64'd0);
        drain("overflow");
        check("ovf_sticky", 128'(overflow), 128'(1));
        check("timeout_cnt2", 128'(timeout_count), 128'(2));

        // Reset while waiting on a read.
        slv_silent[0] = 1'b1;
        t = cyc + 1;
        add_req(0, 1'b0, 230, 64'd0, t + 2);
        send(1'b0, 230, 64'd0);
        repeat (4) @(negedge clk);
        check("midrd_issued", 128'(exp_slv.size()), 128'(0));
        rst_n = 1'b0;
        exp_rsp.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        slv_silent[0] = 1'b0;
        inj_cyc[0] = cyc + 1;
        repeat (3) @(negedge clk);
        check("stray_after_rst", 128'(stray_count), 128'(1));

        t = cyc + 1;
        add_req(0, 1'b0, 240, 64'd0, t + 2);
        add_rsp(slv_tag[0] + 64'd240, t + 4);
        send(1'b0, 240, 64'd0);
        drain("post_rst");
        check("final_timeout", 128'(timeout_count), 128'(0));
        check("final_unmapped", 128'(unmapped_count), 128'(0));
        check("final_overflow", 128'(overflow), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
